sysid_probe_master: RTL and testbench

//  Avalon-MM read master at the far end of the system-ID slave's control_slave port.

---
 rtl/sysid_probe_master_pkg.sv | 26 ++
 rtl/sysid_probe_master_if.sv | 27 ++
 rtl/sysid_timeout_counter.sv | 39 +++
 rtl/sysid_probe_master.sv | 180 ++++++++++++++++++
 tb/tb_sysid_probe_master.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sysid_probe_master_pkg.sv
// Shared types and constants for the system-ID probe master
// and the matching slave generator.
package sysid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ_ID  = 3'd1,
    ST_WAIT_ID = 3'd2,
    ST_REQ_TS  = 3'd3,
    ST_WAIT_TS = 3'd4,
    ST_DONE    = 3'd5,
    ST_FAIL    = 3'd6
  } state_t;

  localparam logic SYSID_ID_ADDR = 1'b0;
  localparam logic SYSID_TS_ADDR = 1'b1;

  localparam logic [31:0] SYSID_EXPECTED_ID = 32'd15;
  localparam logic [31:0] SYSID_EXPECTED_TS = 32'd1411317456;

  function automatic logic is_busy(state_t s);
    return (s == ST_REQ_ID) || (s == ST_WAIT_ID) ||
           (s == ST_REQ_TS) || (s == ST_WAIT_TS);
  endfunction

endpackage

// File: rtl/sysid_probe_master_if.sv
// Avalon-MM read-only bus between the probe master
// and the system-ID control slave.
interface sysid_probe_master_if;

  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata,
    input  avm_readdatavalid
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata,
    output avm_readdatavalid
  );

endinterface

// File: rtl/sysid_timeout_counter.sv
// Saturating per-transaction cycle counter; expired flags
// the cycle whose increment reaches LIMIT.
module sysid_timeout_counter #(
  parameter int LIMIT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIM    = W'(LIMIT);
  localparam logic [W-1:0] LIM_M1 = W'(LIMIT - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LIM)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = enable && (count_q >= LIM_M1);

endmodule

// File: rtl/sysid_probe_master.sv
// Boot-time probe: reads ID and timestamp words from the
// system-ID slave and reports match/mismatch/timeout.
module sysid_probe_master
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = SYSID_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = SYSID_EXPECTED_TS,
  parameter logic        ID_ADDR        = SYSID_ID_ADDR,
  parameter logic        TS_ADDR        = SYSID_TS_ADDR,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  sysid_probe_master_if.master avm,
  output logic                 busy,
  output logic                 done,
  output logic                 id_match,
  output logic                 ts_match,
  output logic                 timeout,
  output logic [31:0]          id_value,
  output logic [31:0]          ts_value
);

  state_t      state_q, state_d;
  logic        read_q, read_d;
  logic        addr_q, addr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        id_match_q, id_match_d;
  logic        ts_match_q, ts_match_d;
  logic        timeout_q, timeout_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;

  logic accept;
  logic rdv;
  logic launch;
  logic fail;
  logic tmo_clear;
  logic tmo_enable;
  logic tmo_expired;

  assign accept = read_q && !avm.avm_waitrequest;
  assign rdv    = avm.avm_readdatavalid;

  assign tmo_enable = is_busy(state_q);
  assign tmo_clear  = (state_d != state_q) &&
                      ((state_d == ST_REQ_ID) ||
                       (state_d == ST_REQ_TS));

  sysid_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_tmo (
    .clock   (clock),
    .reset   (reset),
    .clear   (tmo_clear),
    .enable  (tmo_enable),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d    = state_q;
    read_d     = read_q;
    addr_d     = addr_q;
    busy_d     = busy_q;
    done_d     = done_q;
    id_match_d = id_match_q;
    ts_match_d = ts_match_q;
    timeout_d  = timeout_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;
    launch     = 1'b0;
    fail       = 1'b0;

    unique case (state_q)
      ST_IDLE: launch = AUTO_START || start;
      ST_REQ_ID: begin
        if (accept) begin
          state_d = ST_WAIT_ID;
          read_d  = 1'b0;
        end else begin
          fail = tmo_expired;
        end
      end
      ST_WAIT_ID: begin
        // data beats the limit when both land together
        if (rdv) begin
          id_value_d = avm.avm_readdata;
          id_match_d = (avm.avm_readdata == EXPECTED_ID);
          state_d    = ST_REQ_TS;
          read_d     = 1'b1;
          addr_d     = TS_ADDR;
        end else begin
          fail = tmo_expired;
        end
      end
      ST_REQ_TS: begin
        if (accept) begin
          state_d = ST_WAIT_TS;
          read_d  = 1'b0;
        end else begin
          fail = tmo_expired;
        end
      end
      ST_WAIT_TS: begin
        if (rdv) begin
          ts_value_d = avm.avm_readdata;
          ts_match_d = (avm.avm_readdata == EXPECTED_TS);
          state_d    = ST_DONE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
        end else begin
          fail = tmo_expired;
        end
      end
      ST_DONE, ST_FAIL: launch = start;
      default: state_d = ST_IDLE;
    endcase

    if (fail) begin
      state_d   = ST_FAIL;
      read_d    = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b1;
      timeout_d = 1'b1;
    end

    if (launch) begin
      state_d    = ST_REQ_ID;
      read_d     = 1'b1;
      addr_d     = ID_ADDR;
      busy_d     = 1'b1;
      done_d     = 1'b0;
      timeout_d  = 1'b0;
      id_match_d = 1'b0;
      ts_match_d = 1'b0;
      id_value_d = '0;
      ts_value_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      read_q     <= 1'b0;
      addr_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      id_match_q <= 1'b0;
      ts_match_q <= 1'b0;
      timeout_q  <= 1'b0;
      id_value_q <= '0;
      ts_value_q <= '0;
    end else begin
      state_q    <= state_d;
      read_q     <= read_d;
      addr_q     <= addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      id_match_q <= id_match_d;
      ts_match_q <= ts_match_d;
      timeout_q  <= timeout_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
    end
  end

  assign avm.avm_read    = read_q;
  assign avm.avm_address = addr_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign id_match        = id_match_q;
  assign ts_match        = ts_match_q;
  assign timeout         = timeout_q;
  assign id_value        = id_value_q;
  assign ts_value        = ts_value_q;

endmodule

// File: tb/tb_sysid_probe_master.sv
// Directed bench for sysid_probe_master with an Avalon
// slave model and a result scoreboard.
module tb_sysid_probe_master;

  localparam logic [31:0] EXP_ID = 32'd15;
  localparam logic [31:0] EXP_TS = 32'd1411317456;

  typedef struct {
    logic [31:0] idv;
    logic [31:0] tsv;
    logic        idm;
    logic        tsm;
    logic        to;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;

  logic        busy, done, id_match, ts_match, timeout;
  logic [31:0] id_value, ts_value;

  int          vectors = 0;
  int          errors  = 0;
  exp_t        sb_q[$];

  int          wait_cycles = 0;
  logic [31:0] id_word = EXP_ID;
  logic [31:0] ts_word = EXP_TS;
  bit          drop_ts = 1'b0;
  bit          inj_rdv = 1'b0;
  logic [31:0] inj_data = '0;

  int          stall_cnt;
  int          acc_cnt;
  int          stall_total;
  int          stall_err;
  logic        prev_stall;
  logic        prev_addr;
  logic        rdv_q;
  logic [31:0] rdata_q;
  logic        wreq;

  sysid_probe_master_if avm_if ();

  sysid_probe_master #(
    .TIMEOUT_CYCLES (8),
    .AUTO_START     (1'b1)
  ) dut (
    .clock    (clk),
    .reset    (rst),
    .start    (start),
    .avm      (avm_if),
    .busy     (busy),
    .done     (done),
    .id_match (id_match),
    .ts_match (ts_match),
    .timeout  (timeout),
    .id_value (id_value),
    .ts_value (ts_value)
  );

  always #5 clk = ~clk;

  assign wreq = avm_if.avm_read && (stall_cnt < wait_cycles);
  assign avm_if.avm_waitrequest   = wreq;
  assign avm_if.avm_readdata      = inj_rdv ? inj_data : rdata_q;
  assign avm_if.avm_readdatavalid = rdv_q | inj_rdv;

  // slave: fixed stall per request, 1-cycle read latency
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt  <= 0;
      rdv_q      <= 1'b0;
      rdata_q    <= '0;
      prev_stall <= 1'b0;
      prev_addr  <= 1'b0;
    end else begin
      rdv_q <= 1'b0;
      if (prev_stall && (!avm_if.avm_read ||
          avm_if.avm_address != prev_addr))
        stall_err <= stall_err + 1;
      prev_stall <= avm_if.avm_read && wreq;
      prev_addr  <= avm_if.avm_address;
      if (avm_if.avm_read && !wreq) begin
        stall_cnt <= 0;
        acc_cnt   <= acc_cnt + 1;
        if (!(avm_if.avm_address && drop_ts)) begin
          rdv_q   <= 1'b1;
          rdata_q <= avm_if.avm_address ? ts_word : id_word;
        end
      end else if (avm_if.avm_read) begin
        stall_cnt   <= stall_cnt + 1;
        stall_total <= stall_total + 1;
      end
    end
  end

  initial begin
    acc_cnt = 0;
    stall_total = 0;
    stall_err = 0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] idv,
                          input logic [31:0] tsv,
                          input logic idm, input logic tsm,
                          input logic to);
    exp_t e;
    e.idv = idv;
    e.tsv = tsv;
    e.idm = idm;
    e.tsm = tsm;
    e.to  = to;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    check({tag, "_sb_depth"}, sb_q.size(), 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, "_id_value"}, id_value, e.idv);
      check({tag, "_ts_value"}, ts_value, e.tsv);
      check({tag, "_id_match"}, id_match, e.idm);
      check({tag, "_ts_match"}, ts_match, e.tsm);
      check({tag, "_timeout"}, timeout, e.to);
      check({tag, "_done"}, done, 1);
      check({tag, "_busy"}, busy, 0);
    end
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 60 && !done; i++) tick();
    check({tag, "_done_reached"}, done, 1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  int acc0;
  int stall0;
  int err0;

  initial begin
    // reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_read", avm_if.avm_read, 0);
    check("rst_addr", avm_if.avm_address, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_flags", {id_match, ts_match, timeout}, 0);
    check("rst_values", id_value | ts_value, 0);

    // 1: auto start, zero wait states
    push_exp(EXP_ID, EXP_TS, 1, 1, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("t1_read", avm_if.avm_read, 1);
    check("t1_addr", avm_if.avm_address, 0);
    check("t1_busy", busy, 1);
    tick();
    tick();
    tick();
    check("t1_done_early", done, 0);
    tick();
    check("t1_done_lat4", done, 1);
    sb_check("t1");

    // 2: three wait states per request
    wait_cycles = 3;
    acc0 = acc_cnt;
    stall0 = stall_total;
    err0 = stall_err;
    push_exp(EXP_ID, EXP_TS, 1, 1, 0);
    pulse_start();
    check("t2_restart_read", avm_if.avm_read, 1);
    check("t2_restart_done", done, 0);
    wait_done("t2");
    sb_check("t2");
    check("t2_accepts", acc_cnt - acc0, 2);
    check("t2_stalls", stall_total - stall0, 6);
    check("t2_stable", stall_err - err0, 0);

    // 3: wrong ID
    wait_cycles = 0;
    id_word = 32'd16;
    push_exp(32'd16, EXP_TS, 0, 1, 0);
    pulse_start();
    wait_done("t3");
    sb_check("t3");

    // 4: TS response never arrives
    id_word = EXP_ID;
    drop_ts = 1'b1;
    push_exp(EXP_ID, 32'd0, 1, 0, 1);
    pulse_start();
    for (int i = 0; i < 40; i++) begin
      if (avm_if.avm_read && avm_if.avm_address) break;
      tick();
    end
    check("t4_req_ts",
          {avm_if.avm_read, avm_if.avm_address}, 2'b11);
    repeat (7) tick();
    check("t4_no_tmo_yet", {timeout, done, busy}, 3'b001);
    tick();
    check("t4_tmo", timeout, 1);
    check("t4_read_low", avm_if.avm_read, 0);
    sb_check("t4");
    inj_data = EXP_TS;
    inj_rdv = 1'b1;
    tick();
    inj_rdv = 1'b0;
    tick();
    check("t4_late_ts_value", ts_value, 0);
    check("t4_late_flags",
          {ts_match, id_match, timeout, done}, 4'b0111);
    drop_ts = 1'b0;

    // 5: start during WAIT_ID ignored, after done honoured
    push_exp(EXP_ID, EXP_TS, 1, 1, 0);
    pulse_start();
    check("t5_cleared", {timeout, done, id_match}, 0);
    check("t5_req_id",
          {avm_if.avm_read, avm_if.avm_address}, 2'b10);
    tick();
    check("t5_wait_id", {avm_if.avm_read, busy}, 2'b01);
    pulse_start();
    check("t5_ignored",
          {avm_if.avm_read, avm_if.avm_address}, 2'b11);
    check("t5_id_kept", id_match, 1);
    wait_done("t5a");
    sb_check("t5a");
    pulse_start();
    check("t5_clear_vals", id_value | ts_value, 0);
    check("t5_clear_flags",
          {done, id_match, ts_match, timeout}, 0);
    check("t5_new_req",
          {avm_if.avm_read, avm_if.avm_address, busy},
          3'b101);
    push_exp(EXP_ID, EXP_TS, 1, 1, 0);
    wait_done("t5b");
    sb_check("t5b");

    // 6: reset while REQ_TS is stalled
    wait_cycles = 3;
    pulse_start();
    for (int i = 0; i < 40; i++) begin
      if (avm_if.avm_read && avm_if.avm_address) break;
      tick();
    end
    tick();
    check("t6_stalled",
          {avm_if.avm_read, avm_if.avm_address,
           avm_if.avm_waitrequest}, 3'b111);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_read", avm_if.avm_read, 0);
    check("t6_async_state",
          {busy, done, id_match, ts_match, timeout}, 0);
    check("t6_async_vals", id_value | ts_value, 0);
    repeat (2) @(posedge clk);
    push_exp(EXP_ID, EXP_TS, 1, 1, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("t6_restart",
          {avm_if.avm_read, avm_if.avm_address, busy},
          3'b101);
    wait_done("t6");
    sb_check("t6");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
